// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing and test-pattern source that feeds the video_uut overlay
//   stage. The defaults give 1080p60 CEA timing. The raster advances only on
//   cycles where the pixel clock enable is high.
//
//   Ports:
//     clk_i          clock
//     rst_n_i        asynchronous active-low reset
//     cen_i          pixel clock enable; every counter and output holds when low
//     pat_sel_i      0 colour bars, 1 grid, 2 moving ramp, 3 solid
//     solid_rgb_i    colour used by pattern 3
//     vid_rgb_o      {R,G,B}, 8 bits each; black while blanking
//     vh_blank_o     {Vblank, Hblank}
//     dvh_sync_o     {D_sync (data enable), Vsync, Hsync}
//     frame_start_o  one-clock pulse that comes with pixel (0,0)
//     hcount_o       pixel column, aligned with the video outputs
//     vcount_o       line number, aligned with the video outputs
//
//   Every output is registered from the current counter state, so each
//   output lags the counters by one enabled cycle.
module video_timing_gen #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter int HS_POL   = 1,
   parameter int VS_POL   = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        cen_i,
   input  logic [1:0]  pat_sel_i,
   input  logic [23:0] solid_rgb_i,
   output logic [23:0] vid_rgb_o,
   output logic [1:0]  vh_blank_o,
   output logic [2:0]  dvh_sync_o,
   output logic        frame_start_o,
   output logic [11:0] hcount_o,
   output logic [11:0] vcount_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
   localparam logic [11:0] HS_BEG_C = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END_C = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST_C = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
   localparam logic [11:0] VS_BEG_C = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END_C = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST_C = 12'(V_TOTAL - 1);
   localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);
   localparam logic        HS_ACT   = 1'(HS_POL);
   localparam logic        VS_ACT   = 1'(VS_POL);

   if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_size_chk
      $error("video_timing_gen: H_TOTAL/V_TOTAL must fit in 12 bits");
   end
   if (BAR_W < 1) begin : g_bar_chk
      $error("video_timing_gen: H_ACTIVE must be at least 8");
   end

   logic [11:0] h_cnt, v_cnt;
   logic [7:0]  frame_cnt;
   logic [1:0]  pat_q;
   logic [23:0] solid_q;
   // Bar index and position inside the bar follow h_cnt, so no divider is needed.
   logic [2:0]  bar_idx;
   logic [11:0] bar_px;

   logic        h_wrap, v_wrap, sof;
   logic        hblank, vblank, hs_on, vs_on, de;
   logic [1:0]  pat_eff;
   logic [23:0] solid_eff;
   logic [7:0]  ramp;
   logic [23:0] bar_rgb, rgb_nxt;

   assign h_wrap = (h_cnt == H_LAST_C);
   assign v_wrap = (v_cnt == V_LAST_C);
   assign sof    = (h_cnt == 12'd0) && (v_cnt == 12'd0);

   // Pattern inputs are taken at pixel (0,0). Pixel (0,0) already uses the
   // new selection, so a whole frame always shows the same pattern.
   assign pat_eff   = sof ? pat_sel_i   : pat_q;
   assign solid_eff = sof ? solid_rgb_i : solid_q;

   assign hblank = (h_cnt >= H_ACT_C);
   assign vblank = (v_cnt >= V_ACT_C);
   assign hs_on  = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
   // v_cnt changes only when h_cnt wraps, so vsync edges fall on h_cnt = 0.
   assign vs_on  = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);
   assign de     = ~hblank & ~vblank;
   assign ramp   = h_cnt[7:0] + frame_cnt;

   always_comb begin
      bar_rgb = 24'h000000;
      case (bar_idx)
         3'd0: bar_rgb = 24'hFFFFFF;
         3'd1: bar_rgb = 24'hFFFF00;
         3'd2: bar_rgb = 24'h00FFFF;
         3'd3: bar_rgb = 24'h00FF00;
         3'd4: bar_rgb = 24'hFF00FF;
         3'd5: bar_rgb = 24'hFF0000;
         3'd6: bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
   end

   always_comb begin
      rgb_nxt = 24'h000000;
      if (de) begin
         case (pat_eff)
            2'd0: rgb_nxt = bar_rgb;
            2'd1: rgb_nxt = (h_cnt[5:0] == 6'd0 || v_cnt[5:0] == 6'd0) ?
                            24'hFFFFFF : 24'h202020;
            2'd2: rgb_nxt = {ramp, ramp, ramp};
            default: rgb_nxt = solid_eff;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         h_cnt         <= '0;
         v_cnt         <= '0;
         frame_cnt     <= '0;
         pat_q         <= '0;
         solid_q       <= '0;
         bar_idx       <= '0;
         bar_px        <= '0;
         vid_rgb_o     <= '0;
         vh_blank_o    <= 2'b11;
         dvh_sync_o    <= {1'b0, ~VS_ACT, ~HS_ACT};
         frame_start_o <= 1'b0;
         hcount_o      <= '0;
         vcount_o      <= '0;
      end else begin
         // The pulse clears on any non-enabled clock, so it lasts exactly one clock.
         frame_start_o <= cen_i & sof;
         if (cen_i) begin
            h_cnt <= h_wrap ? 12'd0 : h_cnt + 12'd1;
            if (h_wrap) begin
               v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
               if (v_wrap) frame_cnt <= frame_cnt + 8'd1;
            end

            // Columns past 8*BAR_W stay in bar 7.
            if (h_wrap) begin
               bar_idx <= '0;
               bar_px  <= '0;
            end else if (bar_idx != 3'd7) begin
               if (bar_px == BAR_LAST) begin
                  bar_idx <= bar_idx + 3'd1;
                  bar_px  <= '0;
               end else begin
                  bar_px  <= bar_px + 12'd1;
               end
            end

            if (sof) begin
               pat_q   <= pat_sel_i;
               solid_q <= solid_rgb_i;
            end

            vid_rgb_o  <= rgb_nxt;
            vh_blank_o <= {vblank, hblank};
            dvh_sync_o <= {de, vs_on ? VS_ACT : ~VS_ACT, hs_on ? HS_ACT : ~HS_ACT};
            hcount_o   <= h_cnt;
            vcount_o   <= v_cnt;
         end
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a reduced raster:
// 24 x 12 total, 16 x 8 active. The bench keeps its own position model,
// advanced once for each enabled clock.
module tb_video_timing_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b1;
   logic [1:0]  pat_sel = 2'd0;
   logic [23:0] solid = 24'h0;
   logic [23:0] vid_rgb_o;
   logic [1:0]  vh_blank_o;
   logic [2:0]  dvh_sync_o;
   logic        frame_start_o;
   logic [11:0] hcount_o, vcount_o;

   video_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1), .VS_POL(1)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .cen_i(cen),
      .pat_sel_i(pat_sel), .solid_rgb_i(solid),
      .vid_rgb_o(vid_rgb_o), .vh_blank_o(vh_blank_o), .dvh_sync_o(dvh_sync_o),
      .frame_start_o(frame_start_o), .hcount_o(hcount_o), .vcount_o(vcount_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Position model: pix is the index of the pixel now on the outputs.
   int          pix = -1;
   int          fcnt = 0;
   int          m_pat = 0;
   logic [23:0] m_solid = 24'h0;
   int          clk_n = 0;
   int          last_fs = -1;
   int          fs_gap = 0;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   function automatic logic [23:0] exp_rgb(input int h, input int v);
      logic [7:0] r;
      case (m_pat)
         0: return bars[h / 2];
         1: return (h % 64 == 0 || v % 64 == 0) ? 24'hFFFFFF : 24'h202020;
         2: begin r = 8'(h + fcnt); return {r, r, r}; end
         default: return m_solid;
      endcase
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rgb"},   vid_rgb_o, 24'h0);
      chk({tag, "_blank"}, vh_blank_o, 2'b11);
      chk({tag, "_sync"},  dvh_sync_o, 3'b000);
      chk({tag, "_fs"},    frame_start_o, 1'b0);
      chk({tag, "_hc"},    hcount_o, 12'd0);
      chk({tag, "_vc"},    vcount_o, 12'd0);
   endtask

   task automatic step(input logic c);
      int h, v;
      logic hb, vb, hs, vs, de, fs;
      cen = c;
      @(posedge clk);
      #1;
      clk_n++;
      if (c) begin
         if (pix == 287) begin pix = 0; fcnt = (fcnt + 1) % 256; end
         else pix++;
         if (pix == 0) begin m_pat = pat_sel; m_solid = solid; end
      end
      h  = pix % 24;
      v  = pix / 24;
      hb = (h >= 16);
      vb = (v >= 8);
      hs = (h >= 18 && h < 21);
      vs = (v >= 9 && v < 11);
      de = !hb && !vb;
      fs = c && (pix == 0);
      chk("hcount", hcount_o, h);
      chk("vcount", vcount_o, v);
      chk("blank",  vh_blank_o, {vb, hb});
      chk("sync",   dvh_sync_o, {de, vs, hs});
      chk("fstart", frame_start_o, fs);
      chk("rgb",    vid_rgb_o, de ? exp_rgb(h, v) : 24'h0);
      if (frame_start_o === 1'b1) begin
         fs_gap  = clk_n - last_fs;
         last_fs = clk_n;
      end
   endtask

   initial begin
      int dcnt;
      int nfs;
      logic [23:0] ramp_exp [3] = '{24'h050505, 24'h060606, 24'h070707};

      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst0");
      rst_n = 1'b1;

      // Frame A: colour bars. Switch to solid partway through the frame.
      dcnt = 0;
      for (int i = 0; i < 288; i++) begin
         step(1'b1);
         if (dvh_sync_o[2]) dcnt++;
         if (pix == 0)   chk("bar_h0",  vid_rgb_o, 24'hFFFFFF);
         if (pix == 2)   chk("bar_h2",  vid_rgb_o, 24'hFFFF00);
         if (pix == 15)  chk("bar_h15", vid_rgb_o, 24'h000000);
         if (pix == 96)  begin pat_sel = 2'd3; solid = 24'h123456; end
         if (pix == 100) chk("bar_mid", vid_rgb_o, 24'h00FFFF);
      end
      chk("de_count", dcnt, 128);

      // Frame B: solid. Switch to grid late in the frame.
      for (int i = 0; i < 288; i++) begin
         step(1'b1);
         if (pix == 0) begin
            chk("solid_p0", vid_rgb_o, 24'h123456);
            chk("fs_gap288", fs_gap, 288);
         end
         if (pix == 200) pat_sel = 2'd1;
      end

      // Frame C: grid. Queue the ramp pattern for the next frame.
      for (int i = 0; i < 288; i++) begin
         step(1'b1);
         if (pix == 1)   chk("grid_line0", vid_rgb_o, 24'hFFFFFF);
         if (pix == 25)  chk("grid_inner", vid_rgb_o, 24'h202020);
         if (pix == 200) pat_sel = 2'd2;
      end

      // Frame D: assert reset mid-line at hcount 10.
      for (int i = 0; i < 11; i++) step(1'b1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_async");
      pix = -1; fcnt = 0; m_pat = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst_hold");
      rst_n = 1'b1;

      // Ramp over three frames, starting from frame_cnt 0.
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 288; i++) begin
            step(1'b1);
            if (f == 0 && pix == 0) chk("post_rst_fs", frame_start_o, 1'b1);
            if (pix == 5) chk("ramp_p5", vid_rgb_o, ramp_exp[f]);
         end
      end

      // cen alternating 1,0: each frame doubles to 576 clocks.
      nfs = 0;
      for (int i = 0; i < 1152; i++) begin
         step((i % 2) == 0);
         if (frame_start_o) begin
            if (nfs > 0) chk("fs_gap576", fs_gap, 576);
            nfs++;
         end
      end
      chk("fs_pulses", nfs, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Upstream source stage for the video_uut overlay stage.
- Generates raster timing (Hblank/Vblank, Hsync/Vsync, D_sync data-enable) and a selectable RGB test pattern.
- Outputs connect directly to video_uut's vid_rgb_i, vh_blank_i and dvh_sync_i.
- Defaults are 1080p60 CEA timing; the raster advances only on pixel clock-enable cycles.

Parameters:
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (pixels)
- H_SYNC, 44, hsync width (pixels)
- H_BP, 148, horizontal back porch (pixels)
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 36, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level

Ports:
- clk_i, in, 1, clock
- rst_n_i, in, 1, reset, asynchronous assert, active-low
- cen_i, in, 1, pixel clock enable
- pat_sel_i, in, 2, pattern: 0 colour bars, 1 grid, 2 moving ramp, 3 solid
- solid_rgb_i, in, 24, colour for pattern 3
- vid_rgb_o, out, 24, R[23:16] G[15:8] B[7:0]
- vh_blank_o, out, 2, {Vblank, Hblank}
- dvh_sync_o, out, 3, {D_sync, Vsync, Hsync}
- frame_start_o, out, 1, one-cycle pulse at first pixel of each frame
- hcount_o, out, 12, current pixel column (registered with the video outputs)
- vcount_o, out, 12, current line (registered with the video outputs)

Behaviour:
- Reset is asynchronous assert, active-low, with synchronous release. While reset is asserted:
  - h_cnt = v_cnt = 0
  - frame_cnt (8-bit) = 0
  - latched pattern = 0
  - vid_rgb_o = 0
  - vh_blank_o = 2'b11
  - dvh_sync_o = {1'b0, ~VS_POL, ~HS_POL}
  - frame_start_o = 0
  - hcount_o = vcount_o = 0
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters change only on cycles with cen_i = 1.
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - On an h_cnt wrap, v_cnt increments; v_cnt wraps from V_TOTAL-1 to 0.
  - When v_cnt wraps, frame_cnt increments (8-bit, wraps 255 -> 0).
- Decode from the current counters:
  - hblank = (h_cnt >= H_ACTIVE)
  - vblank = (v_cnt >= V_ACTIVE)
  - hsync active while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vsync active while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; vsync transitions are aligned to h_cnt = 0
  - D_sync = ~hblank & ~vblank
  - Each sync output drives its POL level when active and the inverted level otherwise.
- Output latency: every output is registered and updates only when cen_i = 1. Outputs reflect the counter state of the preceding enabled cycle (1 enabled cycle of latency). With cen_i = 0 all outputs hold.
- frame_start_o is 1 for exactly the one enabled cycle whose registered counters are (0,0); otherwise 0, including during cen_i = 0 cycles.
- pat_sel_i and solid_rgb_i are sampled only when h_cnt = 0 and v_cnt = 0 on an enabled cycle. A change mid-frame takes effect at the next frame, so there is no tearing.
- RGB during blanking (D_sync = 0) is 24'h000000.
- RGB in the active region, by latched pattern:
  - Pattern 0, colour bars: BAR_W = H_ACTIVE/8, integer division. Use a bar index plus an intra-bar counter; no divider. Bar order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Columns at or beyond 8*BAR_W stay at bar 7.
  - Pattern 1, grid: FFFFFF where h_cnt[5:0] = 0 or v_cnt[5:0] = 0, else 202020.
  - Pattern 2, moving ramp: R = G = B = (h_cnt[7:0] + frame_cnt) mod 256.
  - Pattern 3, solid: the latched solid_rgb_i.
- Parameter sums must fit in 12 bits (H_TOTAL <= 4095); elaboration asserts this.

Test Plan:
All scenarios use small parameters: H_ACTIVE 16, H_FP 2, H_SYNC 3, H_BP 3 (H_TOTAL 24); V_ACTIVE 8, V_FP 1, V_SYNC 2, V_BP 1 (V_TOTAL 12); HS_POL = VS_POL = 1.
1. Timing, cen_i = 1: Hblank rises on the output 1 cycle after h_cnt reaches 16. Hsync is high for hcount_o 18..20. Vsync is high for vcount_o 9..10. D_sync is high for 128 cycles per 288-cycle frame. frame_start_o pulses every 288 cycles.
2. Pattern 0: pixels at hcount_o 0,1 = FFFFFF; 2,3 = FFFF00; 14,15 = 000000. RGB = 0 whenever D_sync = 0.
3. Change pat_sel_i 0 -> 3 with solid_rgb_i = 123456 at vcount_o 4: the rest of the frame stays colour bars; the next frame is all 123456.
4. Pattern 2 over 3 frames: pixel (hcount_o 5, vcount_o 0) = 05, 06, 07.
5. cen_i toggling 1,0,1,0: outputs hold on the 0 cycles. Frame length becomes 576 clocks. frame_start_o stays a single-clock pulse.
6. Assert rst_n_i mid-line at hcount_o 10: outputs go to reset values immediately without a clock edge. After release, the first enabled cycle produces hcount_o = 0, vcount_o = 0 and frame_start_o = 1.
